// File: rtl/corejtagdebug_tap_multidr_pkg.sv
// Shared definitions for the multi-DR JTAG TAP: state encoding,
// instruction opcode helpers and the IR capture pattern.
package corejtagdebug_tap_pkg;

    localparam logic [3:0] ST_TLR      = 4'h0;
    localparam logic [3:0] ST_RTI      = 4'h1;
    localparam logic [3:0] ST_SEL_DR   = 4'h2;
    localparam logic [3:0] ST_CAP_DR   = 4'h3;
    localparam logic [3:0] ST_SHIFT_DR = 4'h4;
    localparam logic [3:0] ST_EXIT1_DR = 4'h5;
    localparam logic [3:0] ST_PAUSE_DR = 4'h6;
    localparam logic [3:0] ST_EXIT2_DR = 4'h7;
    localparam logic [3:0] ST_UPD_DR   = 4'h8;
    localparam logic [3:0] ST_SEL_IR   = 4'h9;
    localparam logic [3:0] ST_CAP_IR   = 4'hA;
    localparam logic [3:0] ST_SHIFT_IR = 4'hB;
    localparam logic [3:0] ST_EXIT1_IR = 4'hC;
    localparam logic [3:0] ST_PAUSE_IR = 4'hD;
    localparam logic [3:0] ST_EXIT2_IR = 4'hE;
    localparam logic [3:0] ST_UPD_IR   = 4'hF;

    // Value loaded into the IR shift register in CAPTURE_IR ({0..0,01}).
    localparam logic [7:0] IR_CAPTURE = 8'h01;

    // All-ones opcode for an IR of w bits (w in 2..8).
    function automatic logic [7:0] op_bypass(input int w);
        op_bypass = 8'hFF >> (8 - w);
    endfunction

    // IDCODE opcode (1) for an IR of w bits.
    function automatic logic [7:0] op_idcode(input int w);
        op_idcode = 8'h01 & op_bypass(w);
    endfunction

endpackage

// File: rtl/corejtagdebug_tap_multidr_fsm.sv
// IEEE 1149.1 TAP state machine: state register, next-state logic
// and one-hot decode of the states the datapath acts on.
module corejtagdebug_tap_fsm
    import corejtagdebug_tap_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output logic [3:0] state,
    output logic       tlr,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    logic [3:0] next;

    // State register, forced to TEST_LOGIC_RESET by TRST.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) state <= ST_TLR;
        else      state <= next;
    end

    // Standard TAP transitions on TMS.
    always_comb begin
        next = state;
        case (state)
            ST_TLR:      next = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   next = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: next = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: next = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   next = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: next = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: next = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   next = tms ? ST_SEL_DR   : ST_RTI;
            default:     next = ST_TLR;
        endcase
    end

    // Decode of the current state for the datapath.
    always_comb begin
        tlr        = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        case (state)
            ST_TLR:      tlr        = 1'b1;
            ST_CAP_DR:   capture_dr = 1'b1;
            ST_SHIFT_DR: shift_dr   = 1'b1;
            ST_UPD_DR:   update_dr  = 1'b1;
            ST_CAP_IR:   capture_ir = 1'b1;
            ST_SHIFT_IR: shift_ir   = 1'b1;
            ST_UPD_IR:   update_ir  = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: rtl/corejtagdebug_tap_multidr.sv
// JTAG TAP with IDCODE, BYPASS and NUM_USER_DR user data registers.
// Option macro CJTAG_TAP_NEGEDGE_TDO_EN registers TDO/TDO_EN on falling TCK.
module corejtagdebug_tap_multidr
    import corejtagdebug_tap_pkg::*;
#(
    parameter int          IR_WIDTH      = 5,
    parameter logic [31:0] IDCODE        = 32'hDEADC001,
    parameter int          NUM_USER_DR   = 2,
    parameter int          USER_DR_WIDTH = 41,
    parameter int          USER_IR_BASE  = 'h10
)
(
    input  logic                                   TCK,
    input  logic                                   TRSTB,
    input  logic                                   TMS,
    input  logic                                   TDI,
    output logic                                   TDO,
    output logic                                   TDO_EN,
    input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   UDR_CAPTURE_DATA,
    output logic [NUM_USER_DR-1:0]                 UDR_CAPTURE_STROBE,
    output logic [USER_DR_WIDTH-1:0]               UDR_UPDATE_DATA,
    output logic [NUM_USER_DR-1:0]                 UDR_UPDATE_STROBE,
    output logic [3:0]                             TAP_STATE
);

    localparam int DR_WIDTH = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;

    localparam logic [7:0] BYPASS8 = op_bypass(IR_WIDTH);
    localparam logic [7:0] IDCODE8 = op_idcode(IR_WIDTH);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = BYPASS8[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IDCODE8[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_CAPTURE[IR_WIDTH-1:0];

    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;

    logic [IR_WIDTH-1:0]    ir;
    logic [IR_WIDTH-1:0]    ir_shift;
    logic [DR_WIDTH-1:0]    dr_shift;
    logic [DR_WIDTH-1:0]    dr_next;
    logic [DR_WIDTH-1:0]    cap_val;
    logic [NUM_USER_DR-1:0] sel_user;
    logic                   sel_idcode;
    int                     dr_len;
    logic                   tdo_next;
    logic                   en_next;

    corejtagdebug_tap_fsm u_fsm (
        .tck        (TCK),
        .trst       (TRSTB),
        .tms        (TMS),
        .state      (TAP_STATE),
        .tlr        (tlr),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    // Instruction decode; anything unrecognised falls through to BYPASS.
    always_comb begin
        sel_user   = '0;
        sel_idcode = 1'b0;
        if (ir == OP_BYPASS) begin
            sel_idcode = 1'b0;
        end else if (ir == OP_IDCODE) begin
            sel_idcode = 1'b1;
        end else begin
            for (int k = 0; k < NUM_USER_DR; k++) begin
                if (ir == IR_WIDTH'(USER_IR_BASE + k)) sel_user[k] = 1'b1;
            end
        end
        if (sel_idcode)     dr_len = 32;
        else if (|sel_user) dr_len = USER_DR_WIDTH;
        else                dr_len = 1;
    end

    // Capture value for the selected data register.
    always_comb begin
        cap_val = '0;
        if (sel_idcode) cap_val = DR_WIDTH'(IDCODE);
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if (sel_user[k]) begin
                cap_val = DR_WIDTH'(UDR_CAPTURE_DATA[k*USER_DR_WIDTH +: USER_DR_WIDTH]);
            end
        end
    end

    // One shift step over the active length; bits above it are held.
    always_comb begin
        dr_next = dr_shift;
        for (int i = 0; i < DR_WIDTH - 1; i++) begin
            if (i < dr_len - 1) dr_next[i] = dr_shift[i+1];
        end
        for (int i = 0; i < DR_WIDTH; i++) begin
            if (i == dr_len - 1) dr_next[i] = TDI;
        end
    end

    // Instruction shift register and active instruction.
    always_ff @(posedge TCK or posedge TRSTB) begin
        if (TRSTB) begin
            ir_shift <= '0;
            ir       <= OP_IDCODE;
        end else begin
            if (capture_ir)    ir_shift <= IR_CAP;
            else if (shift_ir) ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
            if (tlr)            ir <= OP_IDCODE;
            else if (update_ir) ir <= ir_shift;
        end
    end

    // Shared data shift register; pause/exit states simply hold it.
    always_ff @(posedge TCK or posedge TRSTB) begin
        if (TRSTB) begin
            dr_shift <= '0;
        end else if (capture_dr) begin
            dr_shift <= cap_val;
        end else if (shift_dr) begin
            dr_shift <= dr_next;
        end
    end

    // User register strobes and the parallel update value.
    always_ff @(posedge TCK or posedge TRSTB) begin
        if (TRSTB) begin
            UDR_CAPTURE_STROBE <= '0;
            UDR_UPDATE_STROBE  <= '0;
            UDR_UPDATE_DATA    <= '0;
        end else begin
            UDR_CAPTURE_STROBE <= capture_dr ? sel_user : '0;
            UDR_UPDATE_STROBE  <= update_dr ? sel_user : '0;
            if (update_dr && (|sel_user)) begin
                UDR_UPDATE_DATA <= dr_shift[USER_DR_WIDTH-1:0];
            end
        end
    end

    assign tdo_next = shift_ir ? ir_shift[0] : dr_shift[0];
    assign en_next  = shift_ir | shift_dr;

`ifdef CJTAG_TAP_NEGEDGE_TDO_EN
    // Serial output retimed to the falling edge of TCK.
    always_ff @(negedge TCK or posedge TRSTB) begin
        if (TRSTB) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= tdo_next;
            TDO_EN <= en_next;
        end
    end
`else
    assign TDO    = tdo_next;
    assign TDO_EN = en_next;
`endif

endmodule

// File: tb/tb_corejtagdebug_tap_multidr.sv
// Directed bench for corejtagdebug_tap_multidr with default parameters.
// Drives TMS/TDI on the falling edge and samples TDO there.
module tb_corejtagdebug_tap_multidr;

    logic        TCK = 1'b0;
    logic        TRSTB = 1'b1;
    logic        TMS = 1'b1;
    logic        TDI = 1'b0;
    logic        TDO;
    logic        TDO_EN;
    logic [81:0] cap_data;
    logic [1:0]  cap_strobe;
    logic [40:0] upd_data;
    logic [1:0]  upd_strobe;
    logic [3:0]  tap_state;

    int checks = 0;
    int failures = 0;
    int cap_cnt [2] = '{0, 0};
    int upd_cnt [2] = '{0, 0};

    localparam logic [40:0] CAP0 = 41'h0123456789A;
    localparam logic [40:0] CAP1 = 41'h0CAFEBABE12;

    corejtagdebug_tap_multidr dut (
        .TCK                (TCK),
        .TRSTB              (TRSTB),
        .TMS                (TMS),
        .TDI                (TDI),
        .TDO                (TDO),
        .TDO_EN             (TDO_EN),
        .UDR_CAPTURE_DATA   (cap_data),
        .UDR_CAPTURE_STROBE (cap_strobe),
        .UDR_UPDATE_DATA    (upd_data),
        .UDR_UPDATE_STROBE  (upd_strobe),
        .TAP_STATE          (tap_state)
    );

    always #5 TCK = ~TCK;

    // Count strobe-high cycles, sampled mid-cycle.
    always @(negedge TCK) begin
        if (cap_strobe[0]) cap_cnt[0]++;
        if (cap_strobe[1]) cap_cnt[1]++;
        if (upd_strobe[0]) upd_cnt[0]++;
        if (upd_strobe[1]) upd_cnt[1]++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        @(negedge TCK);
        tdo = TDO;
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    // From RTI: load an instruction, return to RTI.
    task automatic ir_scan(input logic [4:0] op, output logic [4:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, op[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    // From RTI: n-bit DR scan, then one extra RTI cycle.
    task automatic dr_scan(input int n, input logic [63:0] din,
                           output logic [63:0] dout, output logic [11:0] path);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        path[11:8] = tap_state;
        tick(1'b0, 1'b0, b);
        path[7:4] = tap_state;
        tick(1'b0, 1'b0, b);
        path[3:0] = tap_state;
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] dout;
        logic [11:0] path;
        logic [4:0]  irout;
        logic        b;
        int c0, c1, u0, u1;
        logic [40:0] din;

        cap_data = {CAP1, CAP0};
        #12;
        check("rst_state", 64'(tap_state), 64'h0);
        check("rst_tdo", 64'(TDO), 64'h0);
        check("rst_tdo_en", 64'(TDO_EN), 64'h0);
        check("rst_upd_data", 64'(upd_data), 64'h0);
        check("rst_cap_strobe", 64'(cap_strobe), 64'h0);
        check("rst_upd_strobe", 64'(upd_strobe), 64'h0);
        @(negedge TCK);
        TRSTB = 1'b0;

        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
        check("tlr_after_tms", 64'(tap_state), 64'h0);
        tick(1'b0, 1'b0, b);
        check("rti_state", 64'(tap_state), 64'h1);
        dr_scan(32, 64'h0, dout, path);
        check("idcode_path", 64'(path), 64'h234);
        check("idcode_value", dout, 64'hDEADC001);

        ir_scan(5'h1F, irout);
        check("ir_capture", 64'(irout), 64'h01);
        dr_scan(8, 64'hA5, dout, path);
        check("bypass_1f", dout, 64'h4A);

        ir_scan(5'h0A, irout);
        check("ir_capture2", 64'(irout), 64'h01);
        dr_scan(8, 64'h3C, dout, path);
        check("bypass_0a", dout, 64'h78);

        ir_scan(5'h10, irout);
        c0 = cap_cnt[0]; c1 = cap_cnt[1];
        u0 = upd_cnt[0]; u1 = upd_cnt[1];
        dr_scan(41, 64'hFF, dout, path);
        check("udr0_capture", dout, 64'(CAP0));
        check("udr0_update", 64'(upd_data), 64'hFF);
        check("udr0_cap_pulse", 64'(cap_cnt[0] - c0), 64'd1);
        check("udr0_upd_pulse", 64'(upd_cnt[0] - u0), 64'd1);
        check("udr0_cap1_quiet", 64'(cap_cnt[1] - c1), 64'd0);
        check("udr0_upd1_quiet", 64'(upd_cnt[1] - u1), 64'd0);

        ir_scan(5'h11, irout);
        c0 = cap_cnt[0]; c1 = cap_cnt[1];
        u0 = upd_cnt[0]; u1 = upd_cnt[1];
        din = 41'h1F00F0F1234;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 20; i++) begin
            tick(i == 19, din[i], b);
            dout[i] = b;
        end
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, b);
        check("pause_state", 64'(tap_state), 64'h6);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 20; i < 41; i++) begin
            tick(i == 40, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        check("udr1_capture", dout, 64'(CAP1));
        check("udr1_update", 64'(upd_data), 64'(din));
        check("udr1_cap_pulse", 64'(cap_cnt[1] - c1), 64'd1);
        check("udr1_upd_pulse", 64'(upd_cnt[1] - u1), 64'd1);
        check("udr1_cap0_quiet", 64'(cap_cnt[0] - c0), 64'd0);
        check("udr1_upd0_quiet", 64'(upd_cnt[0] - u0), 64'd0);

        c1 = cap_cnt[1]; u1 = upd_cnt[1];
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        check("zero_len_update", 64'(upd_data), 64'(CAP1));
        check("zero_len_cap", 64'(cap_cnt[1] - c1), 64'd1);
        check("zero_len_upd", 64'(upd_cnt[1] - u1), 64'd1);

        ir_scan(5'h10, irout);
        u0 = upd_cnt[0]; u1 = upd_cnt[1];
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, b);
        check("mid_scan_state", 64'(tap_state), 64'h4);
        TRSTB = 1'b1;
        #1;
        check("trst_state", 64'(tap_state), 64'h0);
        check("trst_tdo", 64'(TDO), 64'h0);
        check("trst_tdo_en", 64'(TDO_EN), 64'h0);
        check("trst_upd_data", 64'(upd_data), 64'h0);
        check("trst_strobes", 64'({cap_strobe, upd_strobe}), 64'h0);
        @(negedge TCK);
        TRSTB = 1'b0;
        TMS = 1'b0;
        tick(1'b0, 1'b0, b);
        check("trst_rti", 64'(tap_state), 64'h1);
        dr_scan(32, 64'h0, dout, path);
        check("trst_idcode", dout, 64'hDEADC001);
        check("trst_no_upd0", 64'(upd_cnt[0] - u0), 64'd0);
        check("trst_no_upd1", 64'(upd_cnt[1] - u1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
